// File: rtl/lsu.sv
// Load/store unit: carries one RV32I memory access at a time through IDLE -> ACCESS -> WAIT -> RESP.
// Memory strobes last exactly one cycle; load data is captured and extended during that same cycle.
module lsu #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  Mren,
    output logic [1:0]  Mwen,
    output logic [31:0] raddr,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds its payload while valid is high; ready never depends on valid.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt;

    function automatic logic access_error(input logic wen, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a != 2'b00;
            3'b100:  return wen;
            3'b101:  return wen | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {24'd0, d[7:0]};
            2'b01:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wen_q      <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt        <= 4'd0;
            Mren       <= 2'b00;
            Mwen       <= 2'b00;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= store_mask(req_funct3, req_wdata);
                        if (access_error(req_wen, req_funct3, req_addr[1:0])) begin
                            state      <= S_RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state <= S_ACCESS;
                            Mren  <= req_wen ? 2'b00 : size_code(req_funct3);
                            Mwen  <= req_wen ? size_code(req_funct3) : 2'b00;
                        end
                    end
                end
                S_ACCESS: begin
                    // rdata is combinational from the strobe, so it is valid only in this cycle.
                    Mren       <= 2'b00;
                    Mwen       <= 2'b00;
                    resp_rdata <= wen_q ? 32'd0 : load_ext(funct3_q, rdata);
                    resp_err   <= 1'b0;
                    if (LATENCY == 0) begin
                        state <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign raddr      = addr_q;
    assign waddr      = addr_q;
    assign wdata      = wdata_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: scoreboarded loads/stores against an independent memory-access model,
// plus back-pressure, reset-abandon and LATENCY sweep scenarios.
module tb_lsu;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [31:0] mem_rdata;

    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [1:0]  mren;
    logic [1:0]  mwen;
    logic [1:0]  dbg_state;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] resp_rdata;

    // Memory returns garbage unless the DUT is strobing a read.
    assign rdata = (mren != 2'b00) ? mem_rdata : 32'hdead_beef;

    lsu #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .Mren(mren), .Mwen(mwen), .raddr(raddr), .waddr(waddr), .wdata(wdata),
        .rdata(rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    // Two more instances with LATENCY 0 and 4 share the request inputs.
    logic        x_req_ready[2];
    logic        x_resp_valid[2];
    logic        x_resp_err[2];
    logic [1:0]  x_mren[2];
    logic [1:0]  x_mwen[2];
    logic [1:0]  x_dbg[2];
    logic [31:0] x_raddr[2];
    logic [31:0] x_waddr[2];
    logic [31:0] x_wdata[2];
    logic [31:0] x_rdata[2];
    logic [31:0] x_resp_rdata[2];

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        assign x_rdata[g] = (x_mren[g] != 2'b00) ? mem_rdata : 32'hdead_beef;
        lsu #(.LATENCY((g == 0) ? 0 : 4)) u_x (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(x_req_ready[g]), .req_wen(req_wen),
            .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
            .Mren(x_mren[g]), .Mwen(x_mwen[g]), .raddr(x_raddr[g]), .waddr(x_waddr[g]),
            .wdata(x_wdata[g]), .rdata(x_rdata[g]), .resp_valid(x_resp_valid[g]),
            .resp_ready(resp_ready), .resp_rdata(x_resp_rdata[g]), .resp_err(x_resp_err[g]),
            .dbg_state(x_dbg[g])
        );
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int strobe_cnt = 0;
    logic [1:0]  last_mren;
    logic [1:0]  last_mwen;
    logic [31:0] last_raddr;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [32:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: {err, resp_rdata} for one request.
    function automatic logic [32:0] model(input logic wen, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] rd);
        logic        err;
        logic [31:0] v;
        err = 1'b0;
        v   = 32'd0;
        case (f3)
            3'd0: v = {{24{rd[7]}}, rd[7:0]};
            3'd1: begin err = a[0]; v = {{16{rd[15]}}, rd[15:0]}; end
            3'd2: begin err = (a[1:0] != 2'b00); v = rd; end
            3'd4: begin err = wen; v = {24'd0, rd[7:0]}; end
            3'd5: begin err = wen || a[0]; v = {16'd0, rd[15:0]}; end
            default: err = 1'b1;
        endcase
        if (err || wen) v = 32'd0;
        return {err, v};
    endfunction

    function automatic logic [1:0] exp_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 2'b01;
        if (f3 == 3'd1 || f3 == 3'd5) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return d & 32'h0000_00ff;
        if (f3 == 3'd1) return d & 32'h0000_ffff;
        return d;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && (mren != 2'b00 || mwen != 2'b00)) begin
            strobe_cnt++;
            last_mren  = mren;
            last_mwen  = mwen;
            last_raddr = raddr;
            last_waddr = waddr;
            last_wdata = wdata;
        end
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e[31:0]);
                check("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd);
        int n;
        mem_rdata = rd;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        acc_cyc    = cyc;
        strobe_cnt = 0;
        exp_q.push_back(model(wen, f3, a, rd));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic run_one(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd);
        int lat;
        logic [32:0] e;
        e = model(wen, f3, a, rd);
        issue(wen, f3, a, wd, rd);
        wait_resp(lat);
        check("latency", 32'(lat), e[32] ? 32'd1 : 32'(2 + LAT));
        check("strobe_cycles", 32'(strobe_cnt), e[32] ? 32'd0 : 32'd1);
        if (!e[32] && wen) begin
            check("st_mwen", {30'd0, last_mwen}, {30'd0, exp_size(f3)});
            check("st_mren", {30'd0, last_mren}, 32'd0);
            check("st_waddr", last_waddr, a);
            check("st_wdata", last_wdata, exp_wdata(f3, wd));
        end else if (!e[32]) begin
            check("ld_mren", {30'd0, last_mren}, {30'd0, exp_size(f3)});
            check("ld_mwen", {30'd0, last_mwen}, 32'd0);
            check("ld_raddr", last_raddr, a);
        end
    endtask

    task automatic hold_test();
        int lat;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        issue(1'b0, 3'b101, 32'h8000_0000, 32'd0, 32'h0000_abcd);
        wait_resp(lat);
        check("hold_latency", 32'(lat), 32'(2 + LAT));
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'h0000_abcd);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            if (i == 2) begin
                req_valid  = 1'b1;
                req_wen    = 1'b0;
                req_funct3 = 3'b010;
                req_addr   = 32'h8000_0010;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("ignored_no_resp", {31'd0, resp_valid}, 32'd0);
        check("ignored_no_strobe", 32'(strobe_cnt), 32'd1);
        check("ignored_idle", {30'd0, dbg_state}, 32'd0);
        check("ignored_sb", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_access_test();
        int seen;
        issue(1'b1, 3'b010, 32'h8000_0004, 32'hcafe_f00d, 32'd0);
        @(negedge clk);
        check("racc_mwen", {30'd0, mwen}, 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("racc_mwen_off", {30'd0, mwen}, 32'd0);
        check("racc_mren_off", {30'd0, mren}, 32'd0);
        check("racc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("racc_idle", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen += int'(resp_valid);
        end
        check("racc_no_resp", 32'(seen), 32'd0);
        run_one(1'b0, 3'b100, 32'h8000_0000, 32'd0, 32'h0000_0080);
    endtask

    task automatic sweep_test();
        int c_main;
        int c0;
        int c4;
        logic [31:0] r0;
        logic [31:0] r4;
        c_main = -1;
        c0 = -1;
        c4 = -1;
        r0 = 32'd0;
        r4 = 32'd0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h8000_0008, 32'd0, 32'h1357_2468);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid && c_main < 0) c_main = cyc;
            if (x_resp_valid[0] && c0 < 0) begin c0 = cyc; r0 = x_resp_rdata[0]; end
            if (x_resp_valid[1] && c4 < 0) begin c4 = cyc; r4 = x_resp_rdata[1]; end
        end
        check("sweep_lat0", 32'(c0 - acc_cyc), 32'd2);
        check("sweep_lat1", 32'(c_main - acc_cyc), 32'd3);
        check("sweep_lat4", 32'(c4 - acc_cyc), 32'd6);
        check("sweep_rdata0", r0, 32'h1357_2468);
        check("sweep_rdata4", r4, 32'h1357_2468);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        mem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mren", {30'd0, mren}, 32'd0);
        check("rst_mwen", {30'd0, mwen}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        run_one(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h0000_00f0);
        run_one(1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'd0);
        run_one(1'b0, 3'b010, 32'h8000_0006, 32'd0, 32'h1111_1111);
        run_one(1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'h2222_2222);
        run_one(1'b1, 3'b100, 32'h8000_0000, 32'h0000_00aa, 32'd0);
        run_one(1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'h0000_8001);
        run_one(1'b1, 3'b010, 32'h8000_000c, 32'hdead_cafe, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_one(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                    $urandom(), $urandom());
        end

        hold_test();
        reset_access_test();
        sweep_test();

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Parameters
REQ-001 LATENCY, 1, extra wait cycles after the memory strobe before the response (0..15).

Interface
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  EXU request valid.
REQ-005 req_ready  out  1  LSU can accept a request.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 Mren  out  2  read strobe and length to Memory: 00 idle, 01 byte, 10 half, 11 word.
REQ-011 Mwen  out  2  write strobe and length to Memory, same encoding as Mren.
REQ-012 raddr, waddr  out  32  access address to Memory.
REQ-013 wdata  out  32  store data to Memory.
REQ-014 rdata  in  32  Memory read data, right-aligned, combinational from Mren/raddr.
REQ-015 resp_valid  out  1  response valid.
REQ-016 resp_ready  in  1  WBU accepts the response.
REQ-017 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-018 resp_err  out  1  misaligned or illegal-funct3 access.

Function
REQ-019 FSM states IDLE, ACCESS, WAIT, RESP, all registered; req_ready = 1 only in IDLE.
REQ-020 IDLE: on req_valid && req_ready, latch wen, funct3, addr, wdata.
REQ-021 Error if funct3 is not in {000,001,010,100,101}, if loads use funct3 100/101 as a store (stores allow only 000/001/010), if a half access has addr[0]=1, or if a word access has addr[1:0]!=00.
REQ-022 IDLE -> RESP on an error; no strobe is issued and resp_err=1.
REQ-023 IDLE -> ACCESS otherwise.
REQ-024 ACCESS: lasts exactly 1 cycle; Mren (load) or Mwen (store) = size code; raddr/waddr = latched addr; wdata = latched wdata masked to the size, with upper bits 0.
REQ-025 Mren and Mwen SHALL be 00 in every state except ACCESS, and are never both nonzero.
REQ-026 ACCESS, load: capture rdata in that same cycle and extend it. b sign-extends bit 7; h sign-extends bit 15; bu/hu zero-extend; w passes through.
REQ-027 ACCESS -> WAIT if LATENCY>0, else -> RESP.
REQ-028 WAIT: 4-bit counter loaded with LATENCY-1 on entry; decrement each cycle; go to RESP when the counter is 0. Total WAIT residency = LATENCY cycles.
REQ-029 RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready; on resp_valid && resp_ready, go to IDLE.
REQ-030 Request-to-response latency with resp_ready=1: 2+LATENCY cycles for a good access, 1 cycle for an error. Throughput is 1 request per 3+LATENCY cycles.
REQ-031 Requests presented outside IDLE are ignored (not latched) and need no stall beyond req_ready=0.
REQ-032 Stores respond with resp_rdata=0 and resp_err=0.

Reset
REQ-033 rst_n low at a rising edge: state=IDLE, counter=0, all latches=0, Mren=Mwen=00, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 after the edge.
REQ-034 Reset in any state, including ACCESS, abandons the access. No strobe is asserted in the cycle after reset. No response is ever produced for the abandoned request.

Verification
REQ-035 LATENCY=1, load lb at 0x80000003 with rdata=0x000000F0 -> Mren=01 for one cycle, raddr=0x80000003; resp_rdata=0xFFFFFFF0 and resp_err=0 three cycles after acceptance.
REQ-036 Store sh at 0x80000002, req_wdata=0x12345678 -> Mwen=10 for one cycle, waddr=0x80000002, wdata=0x00005678; response resp_rdata=0.
REQ-037 Load lw at 0x80000006 -> no strobe, resp_err=1 one cycle after acceptance. Load funct3=011 -> resp_err=1.
REQ-038 lhu with rdata=0x0000ABCD, resp_ready held low 5 cycles -> resp_valid and resp_rdata=0x0000ABCD are stable all 5 cycles; req_ready=0 throughout; a new req_valid pulse in that window is ignored.
REQ-039 rst_n low during ACCESS of a store -> Mwen=00 from the next cycle, FSM in IDLE, no resp_valid. A following lbu at 0x80000000 with rdata=0x80 -> resp_rdata=0x00000080.
REQ-040 Sweep LATENCY=0 and LATENCY=4 -> response arrives 2 and 6 cycles after acceptance respectively.
